data_ram_ctrl: RTL and testbench
================================

Name: data_ram_ctrl

Overview:
- Parametrised, clocked successor to the 256x8 data memory.
- Byte-addressable big-endian storage of DEPTH bytes with byte, half-word and word access, and a Req/Ready/Done handshake.
- Programmable read/write latency, signed or unsigned load extension, and error reporting for misaligned, out-of-range or illegal-size accesses.
- Sits between the pipeline MEM stage and storage; the stage stalls on Ready/Done.

Parameters:
- DEPTH, 256, memory size in bytes (power of 2, >= 4).
- ADDR_W, 32, address bus width.
- LATENCY, 1, cycles from request acceptance to completion (>= 1).

Ports:
- Clk  in  1  clock, rising edge.
- ResetN  in  1  asynchronous reset, active-low.
- Req  in  1  access request.
- Ready  out  1  block idle; request accepted on a rising edge while Req=1 and Ready=1.
- ReadWrite  in  1  0 = read, 1 = write.
- Size  in  2  00 byte, 01 half-word, 10 word, 11 illegal.
- Signed  in  1  reads only: 1 sign-extends byte/half, 0 zero-extends.
- Address  in  ADDR_W  byte address.
- DataIn  in  32  write data, right-justified.
- DataOut  out  32  read data.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  error status of the access just completed; valid while Done=1, held until next Done.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, DataOut=0, Done=0, Error=0, Ready=0 while ResetN=0. Memory array is not cleared; the bench preloads it hierarchically (Mem[i]).
- States: IDLE, BUSY.
  - IDLE: Ready=1. On an edge with Req=1, latch Address, DataIn, Size, ReadWrite and Signed; load counter with LATENCY-1; go to BUSY.
  - BUSY: Ready=0. Req is ignored, and inputs may change without effect. On each edge with counter != 0, decrement the counter. On the edge with counter == 0, complete the access, pulse Done=1 for the following cycle, and return to IDLE.
- Latency and throughput: Done is high in the cycle after edge acceptance+LATENCY. Ready is high in that same Done cycle, so back-to-back throughput is one access per LATENCY+1 cycles.
- Error check, evaluated on latched values:
  - Size=11.
  - Half-word with Address[0]=1.
  - Word with Address[1:0] != 0.
  - Address + nbytes > DEPTH, where nbytes = 1, 2 or 4.
  - On error: no memory write, DataOut=0, Error=1, Done still pulses.
- Write, no error:
  - Byte: Mem[A] = DataIn[7:0].
  - Half: Mem[A] = DataIn[15:8], Mem[A+1] = DataIn[7:0].
  - Word: Mem[A..A+3] = DataIn[31:24], [23:16], [15:8], [7:0].
  - DataOut is unchanged; Error=0.
- Read, no error:
  - Byte: DataOut[7:0] = Mem[A].
  - Half: DataOut[15:0] = {Mem[A], Mem[A+1]}.
  - Word: DataOut = {Mem[A], Mem[A+1], Mem[A+2], Mem[A+3]}.
  - Upper bits are sign- or zero-extended per Signed (ignored for word). Error=0.
- Memory is updated and DataOut captured only on the completion edge. A read never reflects a write still in flight; none can be in flight, since there is one outstanding access.
- Hold rule: DataOut and Error hold between Done pulses.
- Reset mid-operation: the pending access is discarded, no write occurs, Done is not pulsed, and the block returns to IDLE after ResetN rises.
- Address bits above log2(DEPTH) take part in the range check only.

Test Plan:
- Preload Mem[0..3] = 85,12,F0,0F. LATENCY=1, word read at addr 0 -> Done exactly 1 cycle after the acceptance edge, DataOut=8512F00F, Error=0.
- Byte read addr 0: Signed=1 -> FFFFFF85; Signed=0 -> 00000085. Half read addr 2, Signed=1 -> FFFFF00F.
- Word write E35D8AC5 at addr 8, then half read addr 10 -> 00008AC5. Byte write B5 at addr 0, then word read addr 0 -> B512F00F.
- Errors, all with Done=1, Error=1, DataOut=0:
  - Word write DEADBEEF at addr 2 -> Mem[2..5] unchanged.
  - Size=11.
  - Word read at addr 254 with DEPTH=256.
- LATENCY=4: word write at addr 12, drive ResetN=0 two cycles after acceptance -> no Done, Mem[12..15] unchanged, Ready=0 during reset and 1 after.
- Req held high with a new Address each cycle, LATENCY=2 -> exactly one access per 3 cycles. Requests presented during BUSY do not execute.

Source files
------------

// File: rtl/data_ram_ctrl.sv
// Clocked big-endian byte-addressable data memory with Req/Ready/Done handshake,
// programmable access latency, load sign/zero extension and access-error reporting.
module data_ram_ctrl #(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Req,
    output logic              Ready,
    input  logic              ReadWrite,
    input  logic [1:0]        Size,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              Done,
    output logic              Error
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [7:0]        Mem [DEPTH];
    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [1:0]        size_q;
    logic              rw_q, sgn_q;
    logic [31:0]       dout_q;
    logic              done_q, err_q, ready_q;

    logic [ADDR_W:0]   nbytes, end_addr;
    logic [AW-1:0]     idx0, idx1, idx2, idx3;
    logic [7:0]        b0, b1, b2, b3;
    logic              err_d, complete;
    logic [31:0]       rdata_d;

    // Everything below works on the latched request, never on live inputs.
    always_comb begin
        case (size_q)
            2'b00:   nbytes = (ADDR_W+1)'(1);
            2'b01:   nbytes = (ADDR_W+1)'(2);
            default: nbytes = (ADDR_W+1)'(4);
        endcase
        end_addr = {1'b0, addr_q} + nbytes;
        err_d = (size_q == 2'b11)
              | ((size_q == 2'b01) & addr_q[0])
              | ((size_q == 2'b10) & (addr_q[1:0] != 2'b00))
              | (end_addr > DEPTH_L);
        idx0 = addr_q[AW-1:0];
        idx1 = idx0 + AW'(1);
        idx2 = idx0 + AW'(2);
        idx3 = idx0 + AW'(3);
        b0 = Mem[idx0];
        b1 = Mem[idx1];
        b2 = Mem[idx2];
        b3 = Mem[idx3];
        case (size_q)
            2'b00:   rdata_d = {{24{sgn_q & b0[7]}}, b0};
            2'b01:   rdata_d = {{16{sgn_q & b0[7]}}, b0, b1};
            default: rdata_d = {b0, b1, b2, b3};
        endcase
        if (err_d) rdata_d = '0;
        complete = (state_q == BUSY) && (cnt_q == '0);
    end

    // An async reset forces IDLE, so a discarded access can never reach this write.
    always_ff @(posedge Clk) begin
        if (complete && rw_q && !err_d) begin
            case (size_q)
                2'b00: Mem[idx0] <= wdata_q[7:0];
                2'b01: begin
                    Mem[idx0] <= wdata_q[15:8];
                    Mem[idx1] <= wdata_q[7:0];
                end
                default: begin
                    Mem[idx0] <= wdata_q[31:24];
                    Mem[idx1] <= wdata_q[23:16];
                    Mem[idx2] <= wdata_q[15:8];
                    Mem[idx3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rw_q    <= 1'b0;
            sgn_q   <= 1'b0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Req && ready_q) begin
                        addr_q  <= Address;
                        wdata_q <= DataIn;
                        size_q  <= Size;
                        rw_q    <= ReadWrite;
                        sgn_q   <= Signed;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                        if (err_d || !rw_q) dout_q <= rdata_d;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ready   = ready_q;
    assign DataOut = dout_q;
    assign Done    = done_q;
    assign Error   = err_q;
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: three instances at LATENCY 1, 4 and 2 driven by
// per-scenario tasks, with expected completions queued per instance.
module tb_data_ram_ctrl;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [NI];
    logic        req   [NI];
    logic        rw    [NI];
    logic [1:0]  size  [NI];
    logic        sgn   [NI];
    logic [31:0] addr  [NI];
    logic [31:0] din   [NI];
    logic        rdy   [NI];
    logic [31:0] dout  [NI];
    logic        done  [NI];
    logic        err   [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        data_ram_ctrl #(
            .DEPTH(256), .ADDR_W(32), .LATENCY((k == 0) ? 1 : ((k == 1) ? 4 : 2))
        ) u_dut (
            .Clk(clk), .ResetN(rst_n[k]), .Req(req[k]), .Ready(rdy[k]),
            .ReadWrite(rw[k]), .Size(size[k]), .Signed(sgn[k]), .Address(addr[k]),
            .DataIn(din[k]), .DataOut(dout[k]), .Done(done[k]), .Error(err[k])
        );
    end

    typedef struct { logic [31:0] data; logic err; } exp_t;
    typedef struct {
        string nm; logic w; logic [1:0] s; logic sg;
        logic [31:0] a; logic [31:0] d; logic [31:0] ed; logic ee;
    } acc_t;

    exp_t        sbq [NI][$];
    logic [31:0] mdout [NI];
    int          passed = 0;
    int          total  = 0;

    // Drives one request and returns the number of edges from acceptance to Done.
    task automatic xfer(input int k, input logic w, input logic [1:0] s, input logic sg,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output bit ok);
        ok = 1'b0;
        lat = 0;
        for (int i = 0; i < 50 && !rdy[k]; i++) begin @(posedge clk); #1; end
        if (!rdy[k]) return;
        req[k] = 1'b1; rw[k] = w; size[k] = s; sgn[k] = sg; addr[k] = a; din[k] = d;
        @(posedge clk); #1;
        req[k] = 1'b0; rw[k] = 1'($urandom); size[k] = 2'($urandom);
        addr[k] = $urandom; din[k] = $urandom;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done[k]) begin lat = c; ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (rdy[0] !== 1'b0) $display("FAIL reset_ready got %b want 0", rdy[0]); else passed++;
        total++; if (done[0] !== 1'b0) $display("FAIL reset_done got %b want 0", done[0]); else passed++;
        total++; if (err[0] !== 1'b0) $display("FAIL reset_error got %b want 0", err[0]); else passed++;
        total++; if (dout[0] !== 32'h0) $display("FAIL reset_dataout got %h want 0", dout[0]); else passed++;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
        for (int i = 0; i < 5 && !rdy[0]; i++) begin @(posedge clk); #1; end
        total++; if (rdy[0] !== 1'b1) $display("FAIL reset_release_ready got %b want 1", rdy[0]); else passed++;
    endtask

    task automatic test_read();
        acc_t tbl[$];
        tbl.push_back('{"rd_word",    1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 32'h8512F00F, 1'b0});
        tbl.push_back('{"rd_word_sg", 1'b0, 2'b10, 1'b1, 32'd0, 32'd0, 32'h8512F00F, 1'b0});
        tbl.push_back('{"rd_byte_s",  1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 32'hFFFFFF85, 1'b0});
        tbl.push_back('{"rd_byte_u",  1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 32'h00000085, 1'b0});
        tbl.push_back('{"rd_half_s",  1'b0, 2'b01, 1'b1, 32'd2, 32'd0, 32'hFFFFF00F, 1'b0});
        foreach (tbl[i]) begin
            exp_t e; int lat; bit ok;
            e.err  = tbl[i].ee;
            e.data = (tbl[i].w && !tbl[i].ee) ? mdout[0] : tbl[i].ed;
            mdout[0] = e.data;
            sbq[0].push_back(e);
            xfer(0, tbl[i].w, tbl[i].s, tbl[i].sg, tbl[i].a, tbl[i].d, lat, ok);
            e = sbq[0].pop_front();
            total++; if (!ok || lat != 1) $display("FAIL %s latency got %0d want 1", tbl[i].nm, lat); else passed++;
            total++; if (dout[0] !== e.data) $display("FAIL %s data got %h want %h", tbl[i].nm, dout[0], e.data); else passed++;
            total++; if (err[0] !== e.err) $display("FAIL %s error got %b want %b", tbl[i].nm, err[0], e.err); else passed++;
            @(posedge clk); #1;
            total++; if (done[0] !== 1'b0) $display("FAIL %s done_width got %b want 0", tbl[i].nm, done[0]); else passed++;
        end
    endtask

    task automatic test_write_read();
        acc_t tbl[$];
        tbl.push_back('{"wr_word",    1'b1, 2'b10, 1'b0, 32'd8,  32'hE35D8AC5, 32'h0, 1'b0});
        tbl.push_back('{"rd_half10",  1'b0, 2'b01, 1'b0, 32'd10, 32'h0, 32'h00008AC5, 1'b0});
        tbl.push_back('{"rd_half8s",  1'b0, 2'b01, 1'b1, 32'd8,  32'h0, 32'hFFFFE35D, 1'b0});
        tbl.push_back('{"wr_byte",    1'b1, 2'b00, 1'b0, 32'd0,  32'hAABBCCB5, 32'h0, 1'b0});
        tbl.push_back('{"rd_word0",   1'b0, 2'b10, 1'b0, 32'd0,  32'h0, 32'hB512F00F, 1'b0});
        tbl.push_back('{"wr_half",    1'b1, 2'b01, 1'b0, 32'd20, 32'h99991234, 32'h0, 1'b0});
        tbl.push_back('{"rd_byte21",  1'b0, 2'b00, 1'b1, 32'd21, 32'h0, 32'h00000034, 1'b0});
        tbl.push_back('{"rd_byte20",  1'b0, 2'b00, 1'b1, 32'd20, 32'h0, 32'h00000012, 1'b0});
        foreach (tbl[i]) begin
            exp_t e; int lat; bit ok;
            e.err  = tbl[i].ee;
            e.data = (tbl[i].w && !tbl[i].ee) ? mdout[0] : tbl[i].ed;
            mdout[0] = e.data;
            sbq[0].push_back(e);
            xfer(0, tbl[i].w, tbl[i].s, tbl[i].sg, tbl[i].a, tbl[i].d, lat, ok);
            e = sbq[0].pop_front();
            total++; if (!ok || lat != 1) $display("FAIL %s latency got %0d want 1", tbl[i].nm, lat); else passed++;
            total++; if (dout[0] !== e.data) $display("FAIL %s data got %h want %h", tbl[i].nm, dout[0], e.data); else passed++;
            total++; if (err[0] !== e.err) $display("FAIL %s error got %b want %b", tbl[i].nm, err[0], e.err); else passed++;
        end
    endtask

    task automatic test_errors();
        acc_t tbl[$];
        logic [7:0] m_exp [4] = '{8'hF0, 8'h0F, 8'h04, 8'h05};
        tbl.push_back('{"err_wr_misal", 1'b1, 2'b10, 1'b0, 32'd2,   32'hDEADBEEF, 32'h0, 1'b1});
        tbl.push_back('{"err_size11",   1'b0, 2'b11, 1'b0, 32'd0,   32'h0, 32'h0, 1'b1});
        tbl.push_back('{"err_word254",  1'b0, 2'b10, 1'b0, 32'd254, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"err_half255",  1'b0, 2'b01, 1'b0, 32'd255, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"err_byte256",  1'b0, 2'b00, 1'b0, 32'd256, 32'h0, 32'h0, 1'b1});
        tbl.push_back('{"ok_byte255",   1'b0, 2'b00, 1'b1, 32'd255, 32'h0, 32'hFFFFFFFF, 1'b0});
        tbl.push_back('{"ok_word252",   1'b0, 2'b10, 1'b0, 32'd252, 32'h0, 32'hFCFDFEFF, 1'b0});
        tbl.push_back('{"err_half1",    1'b0, 2'b01, 1'b0, 32'd1,   32'h0, 32'h0, 1'b1});
        foreach (tbl[i]) begin
            exp_t e; int lat; bit ok;
            e.err  = tbl[i].ee;
            e.data = (tbl[i].w && !tbl[i].ee) ? mdout[0] : tbl[i].ed;
            mdout[0] = e.data;
            sbq[0].push_back(e);
            xfer(0, tbl[i].w, tbl[i].s, tbl[i].sg, tbl[i].a, tbl[i].d, lat, ok);
            e = sbq[0].pop_front();
            total++; if (!ok || lat != 1) $display("FAIL %s latency got %0d want 1", tbl[i].nm, lat); else passed++;
            total++; if (dout[0] !== e.data) $display("FAIL %s data got %h want %h", tbl[i].nm, dout[0], e.data); else passed++;
            total++; if (err[0] !== e.err) $display("FAIL %s error got %b want %b", tbl[i].nm, err[0], e.err); else passed++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++; if (err[0] !== 1'b1) $display("FAIL err_hold error got %b want 1", err[0]); else passed++;
        total++; if (dout[0] !== 32'h0) $display("FAIL err_hold data got %h want 0", dout[0]); else passed++;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (g_dut[0].u_dut.Mem[2+j] !== m_exp[j])
                $display("FAIL err_nowrite mem[%0d] got %h want %h", 2+j, g_dut[0].u_dut.Mem[2+j], m_exp[j]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        exp_t e; int lat; bit ok;
        for (int i = 0; i < 50 && !rdy[1]; i++) begin @(posedge clk); #1; end
        req[1] = 1'b1; rw[1] = 1'b1; size[1] = 2'b10; sgn[1] = 1'b0; addr[1] = 32'd12; din[1] = 32'h11223344;
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n[1] = 1'b0;
        #1;
        total++; if (rdy[1] !== 1'b0) $display("FAIL midrst_ready got %b want 0", rdy[1]); else passed++;
        repeat (3) begin
            @(posedge clk); #1;
            if (done[1]) ndone++;
        end
        total++; if (rdy[1] !== 1'b0) $display("FAIL midrst_ready_hold got %b want 0", rdy[1]); else passed++;
        rst_n[1] = 1'b1;
        mdout[1] = 32'h0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done[1]) ndone++;
        end
        total++; if (ndone != 0) $display("FAIL midrst_done got %0d pulses want 0", ndone); else passed++;
        total++; if (rdy[1] !== 1'b1) $display("FAIL midrst_ready_after got %b want 1", rdy[1]); else passed++;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (g_dut[1].u_dut.Mem[12+j] !== 8'(12+j))
                $display("FAIL midrst_nowrite mem[%0d] got %h want %h", 12+j, g_dut[1].u_dut.Mem[12+j], 8'(12+j));
            else passed++;
        end
        e.data = 32'h0C0D0E0F; e.err = 1'b0;
        sbq[1].push_back(e);
        xfer(1, 1'b0, 2'b10, 1'b0, 32'd12, 32'h0, lat, ok);
        e = sbq[1].pop_front();
        total++; if (!ok || lat != 4) $display("FAIL lat4 latency got %0d want 4", lat); else passed++;
        total++; if (dout[1] !== e.data) $display("FAIL lat4 data got %h want %h", dout[1], e.data); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 50 && !rdy[2]; i++) begin @(posedge clk); #1; end
        for (int c = 0; c <= 9; c += 3) begin
            exp_t e;
            e.data = {8'(4*c), 8'(4*c+1), 8'(4*c+2), 8'(4*c+3)};
            e.err  = 1'b0;
            sbq[2].push_back(e);
        end
        req[2] = 1'b1; rw[2] = 1'b0; size[2] = 2'b10; sgn[2] = 1'b0; addr[2] = 32'd0;
        for (int e = 0; e < 15; e++) begin
            logic exp_done;
            @(posedge clk); #1;
            exp_done = (e % 3 == 2) && (e <= 11);
            total++;
            if (done[2] !== exp_done) $display("FAIL b2b_done edge %0d got %b want %b", e, done[2], exp_done);
            else passed++;
            if (done[2] && sbq[2].size() > 0) begin
                exp_t x;
                x = sbq[2].pop_front();
                total++;
                if (dout[2] !== x.data) $display("FAIL b2b_data edge %0d got %h want %h", e, dout[2], x.data);
                else passed++;
            end
            req[2]  = (e + 1 <= 11);
            addr[2] = 32'((e + 1) * 4);
        end
        req[2] = 1'b0;
        total++;
        if (sbq[2].size() != 0) $display("FAIL b2b_count got %0d left want 0", sbq[2].size());
        else passed++;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            rst_n[k] = 1'b0; req[k] = 1'b0; rw[k] = 1'b0; size[k] = 2'b00;
            sgn[k] = 1'b0; addr[k] = '0; din[k] = '0; mdout[k] = '0;
        end
        for (int i = 0; i < 256; i++) begin
            g_dut[0].u_dut.Mem[i] = 8'(i);
            g_dut[1].u_dut.Mem[i] = 8'(i);
            g_dut[2].u_dut.Mem[i] = 8'(i);
        end
        g_dut[0].u_dut.Mem[0] = 8'h85;
        g_dut[0].u_dut.Mem[1] = 8'h12;
        g_dut[0].u_dut.Mem[2] = 8'hF0;
        g_dut[0].u_dut.Mem[3] = 8'h0F;
        test_reset();
        test_read();
        test_write_read();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
